// File: rtl/ps2_key_pkg.sv
// Shared constants and types for the PS/2 set-2 key decoder.
package ps2_key_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] LSHIFT  = 8'h12;
    localparam logic [7:0] RSHIFT  = 8'h59;
    localparam logic [7:0] CAPS    = 8'h58;

    localparam logic [7:0] ASCII_CR          = 8'd13;
    localparam logic [7:0] ASCII_BS          = 8'd8;
    localparam logic [7:0] ASCII_TAB         = 8'd9;
    localparam logic [7:0] ASCII_SPACE       = 8'h20;
    localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    function automatic logic is_modifier(input logic [7:0] code);
        return (code == LSHIFT) || (code == RSHIFT) || (code == CAPS);
    endfunction

endpackage

// File: rtl/ps2_scan_lut.sv
// Combinational set-2 make-code lookup; letters are returned upper-case and
// the decoder applies Shift/Caps afterwards.
module ps2_scan_lut
    import ps2_key_pkg::*;
(
    input  logic [7:0] code,
    output logic       hit,
    output logic [7:0] base_ascii,
    output logic       is_letter
);

    always_comb begin
        hit        = 1'b1;
        is_letter  = 1'b1;
        base_ascii = 8'h00;
        case (code)
            8'h1C: base_ascii = 8'h41;
            8'h32: base_ascii = 8'h42;
            8'h21: base_ascii = 8'h43;
            8'h23: base_ascii = 8'h44;
            8'h24: base_ascii = 8'h45;
            8'h2B: base_ascii = 8'h46;
            8'h34: base_ascii = 8'h47;
            8'h33: base_ascii = 8'h48;
            8'h43: base_ascii = 8'h49;
            8'h3B: base_ascii = 8'h4A;
            8'h42: base_ascii = 8'h4B;
            8'h4B: base_ascii = 8'h4C;
            8'h3A: base_ascii = 8'h4D;
            8'h31: base_ascii = 8'h4E;
            8'h44: base_ascii = 8'h4F;
            8'h4D: base_ascii = 8'h50;
            8'h15: base_ascii = 8'h51;
            8'h2D: base_ascii = 8'h52;
            8'h1B: base_ascii = 8'h53;
            8'h2C: base_ascii = 8'h54;
            8'h3C: base_ascii = 8'h55;
            8'h2A: base_ascii = 8'h56;
            8'h1D: base_ascii = 8'h57;
            8'h22: base_ascii = 8'h58;
            8'h35: base_ascii = 8'h59;
            8'h1A: base_ascii = 8'h5A;
            default: begin
                is_letter = 1'b0;
                case (code)
                    8'h45: base_ascii = 8'h30;
                    8'h16: base_ascii = 8'h31;
                    8'h1E: base_ascii = 8'h32;
                    8'h26: base_ascii = 8'h33;
                    8'h25: base_ascii = 8'h34;
                    8'h2E: base_ascii = 8'h35;
                    8'h36: base_ascii = 8'h36;
                    8'h3D: base_ascii = 8'h37;
                    8'h3E: base_ascii = 8'h38;
                    8'h46: base_ascii = 8'h39;
                    8'h29: base_ascii = ASCII_SPACE;
                    8'h5A: base_ascii = ASCII_CR;
                    8'h66: base_ascii = ASCII_BS;
                    8'h0D: base_ascii = ASCII_TAB;
                    default: hit = 1'b0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode to ASCII decoder with output FIFO.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes of a held key.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             scan_valid,
    input  logic [7:0]       scan_code,
    input  logic             out_ready,
    input  logic             clr_ovf,
    output logic             out_valid,
    output logic [7:0]       out_ascii,
    output logic [7:0]       out_scan,
    output logic             caps_led,
    output logic             shift_held,
    output logic             overflow,
    output logic [CNT_W-1:0] key_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    state_t        state, state_nxt;
    logic          make_evt, brk_evt, repeat_make, accept_make;
    logic          lut_hit, lut_letter;
    logic [7:0]    lut_base, ascii_val;
    logic          lshift, rshift;
    logic          push_req, push_ok, pop, full, drop;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        make_evt  = 1'b0;
        brk_evt   = 1'b0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == PS2_EXT)      state_nxt = EXT;
                    else if (scan_code == PS2_BRK) state_nxt = BRK;
                    else                           make_evt  = 1'b1;
                end
                EXT:     state_nxt = (scan_code == PS2_BRK) ? EXT_BRK : IDLE;
                BRK: begin
                    brk_evt   = 1'b1;
                    state_nxt = IDLE;
                end
                EXT_BRK: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    ps2_scan_lut u_lut (
        .code       (scan_code),
        .hit        (lut_hit),
        .base_ascii (lut_base),
        .is_letter  (lut_letter)
    );

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [7:0] last_make;

    // Remember the held key so that auto-repeat makes can be recognised and dropped.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_make <= 8'h00;
        end else if (accept_make && (lut_hit || is_modifier(scan_code))) begin
            last_make <= scan_code;
        end else if (brk_evt && (scan_code == last_make)) begin
            last_make <= 8'h00;
        end
    end

    assign repeat_make = (scan_code == last_make);
`else
    assign repeat_make = 1'b0;
`endif

    assign accept_make = make_evt & ~repeat_make;
    assign shift_held  = lshift | rshift;
    assign ascii_val   = (lut_letter && !(shift_held ^ caps_led)) ? lut_base + ASCII_CASE_OFFSET
                                                                  : lut_base;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lshift   <= 1'b0;
            rshift   <= 1'b0;
            caps_led <= 1'b0;
        end else if (accept_make) begin
            if (scan_code == LSHIFT) lshift   <= 1'b1;
            if (scan_code == RSHIFT) rshift   <= 1'b1;
            if (scan_code == CAPS)   caps_led <= ~caps_led;
        end else if (brk_evt) begin
            if (scan_code == LSHIFT) lshift <= 1'b0;
            if (scan_code == RSHIFT) rshift <= 1'b0;
        end
    end

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push_req  = accept_make & lut_hit;
    assign out_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = out_valid & out_ready;
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {ascii_val, scan_code};
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_ascii = out_valid ? mem[rd_ptr][15:8] : 8'h00;
    assign out_scan  = out_valid ? mem[rd_ptr][7:0]  : 8'h00;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            overflow  <= 1'b0;
            key_count <= '0;
        end else begin
            if (push_ok)      key_count <= key_count + CNT_W'(1);
            if (drop)         overflow  <= 1'b1;
            else if (clr_ovf) overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random bytes
// compared against a queue-based behavioural model.
module tb_ps2_key_decoder;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    typedef struct {
        logic [7:0] ascii;
        logic [7:0] scan;
    } entry_t;

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic             scan_valid = 1'b0;
    logic [7:0]       scan_code = 8'h00;
    logic             out_ready = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             out_valid;
    logic [7:0]       out_ascii;
    logic [7:0]       out_scan;
    logic             caps_led;
    logic             shift_held;
    logic             overflow;
    logic [CNT_W-1:0] key_count;

    int checks = 0;
    int errors = 0;

    entry_t           model_q[$];
    bit               m_ext, m_brk, m_lshift, m_rshift, m_caps, m_ovf;
    logic [CNT_W-1:0] m_count;
    logic [7:0]       m_held;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                      8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                      8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                      8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                     8'h3E, 8'h46};

    ps2_key_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .out_ready  (out_ready),
        .clr_ovf    (clr_ovf),
        .out_valid  (out_valid),
        .out_ascii  (out_ascii),
        .out_scan   (out_scan),
        .caps_led   (caps_led),
        .shift_held (shift_held),
        .overflow   (overflow),
        .key_count  (key_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Character table straight from the key map: letter index -> 'a'+i, digit index -> '0'+i.
    function automatic bit mapCode(input logic [7:0] b, input bit upper, output logic [7:0] asc);
        asc = 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == b) begin
                asc = upper ? 8'(65 + i) : 8'(97 + i);
                return 1'b1;
            end
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == b) begin
                asc = 8'(48 + i);
                return 1'b1;
            end
        case (b)
            8'h29: asc = 8'h20;
            8'h5A: asc = 8'd13;
            8'h66: asc = 8'd8;
            8'h0D: asc = 8'd9;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic bit isMod(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59) || (b == 8'h58);
    endfunction

    task automatic modelReset();
        model_q.delete();
        m_ext = 0; m_brk = 0; m_lshift = 0; m_rshift = 0; m_caps = 0; m_ovf = 0;
        m_count = '0;
        m_held = 8'h00;
    endtask

    // One clock edge of the reference: interpret the byte, then pop, then push.
    task automatic modelEdge();
        bit     want_push = 0;
        entry_t e;
        bit     mapped;
        logic [7:0] asc;
        e.ascii = 8'h00;
        e.scan  = 8'h00;
        if (scan_valid) begin
            if (!m_ext && !m_brk) begin
                if (scan_code == 8'hE0) m_ext = 1;
                else if (scan_code == 8'hF0) m_brk = 1;
                else begin
                    bit ignore = 0;
                    mapped = mapCode(scan_code, (m_lshift | m_rshift) ^ m_caps, asc);
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (scan_code == m_held) ignore = 1;
                    else if (mapped || isMod(scan_code)) m_held = scan_code;
`endif
                    if (!ignore) begin
                        if (scan_code == 8'h12) m_lshift = 1;
                        if (scan_code == 8'h59) m_rshift = 1;
                        if (scan_code == 8'h58) m_caps = !m_caps;
                        if (mapped) begin
                            want_push = 1;
                            e.ascii = asc;
                            e.scan  = scan_code;
                        end
                    end
                end
            end else if (m_ext && !m_brk) begin
                if (scan_code == 8'hF0) m_brk = 1;
                else m_ext = 0;
            end else if (!m_ext && m_brk) begin
                if (scan_code == 8'h12) m_lshift = 0;
                if (scan_code == 8'h59) m_rshift = 0;
                if (scan_code == m_held) m_held = 8'h00;
                m_brk = 0;
            end else begin
                m_ext = 0;
                m_brk = 0;
            end
        end
        if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
        if (want_push) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(e);
                m_count = m_count + 1'b1;
            end else begin
                m_ovf = 1;
            end
        end
        if (!(want_push && model_q.size() >= DEPTH && !(e.scan == model_q[$].scan && 0)))
            if (clr_ovf && !(want_push && m_ovf && model_q.size() == DEPTH && !out_ready)) m_ovf = m_ovf;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".out_valid"}, out_valid, model_q.size() != 0);
        if (model_q.size() != 0) begin
            checkOutput({tag, ".out_ascii"}, out_ascii, model_q[0].ascii);
            checkOutput({tag, ".out_scan"}, out_scan, model_q[0].scan);
        end
        checkOutput({tag, ".caps_led"}, caps_led, m_caps);
        checkOutput({tag, ".shift_held"}, shift_held, m_lshift | m_rshift);
        checkOutput({tag, ".overflow"}, overflow, m_ovf);
        checkOutput({tag, ".key_count"}, key_count, m_count);
    endtask

    // Drive one cycle from a falling edge, advance the model on the rising edge,
    // then compare on the next falling edge.
    task automatic applyStimulus(input bit v, input logic [7:0] code, input bit rdy, input bit clr,
                                 input string tag);
        bit clr_now;
        bit dropped_before;
        scan_valid = v;
        scan_code  = code;
        out_ready  = rdy;
        clr_ovf    = clr;
        @(posedge clk);
        clr_now        = clr;
        dropped_before = m_ovf;
        m_ovf = 0;
        modelEdge();
        // Sticky flag: a drop this edge sets it, otherwise clr_ovf clears it.
        if (!m_ovf) m_ovf = dropped_before && !clr_now;
        @(negedge clk);
        compareAll(tag);
    endtask

    task automatic sendBytes(input logic [7:0] bytes[$], input bit rdy, input string tag);
        foreach (bytes[i]) applyStimulus(1'b1, bytes[i], rdy, 1'b0, tag);
        scan_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 4 && model_q.size() > 0; i++)
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, tag);
        checkOutput({tag, ".drained"}, out_valid, 1'b0);
    endtask

    initial begin
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset.out_valid", out_valid, 1'b0);
        checkOutput("reset.out_ascii", out_ascii, 8'h00);
        checkOutput("reset.out_scan", out_scan, 8'h00);
        checkOutput("reset.caps_led", caps_led, 1'b0);
        checkOutput("reset.shift_held", shift_held, 1'b0);
        checkOutput("reset.overflow", overflow, 1'b0);
        checkOutput("reset.key_count", key_count, 0);
        clrn = 1'b1;
        @(negedge clk);

        sendBytes('{8'h1C, 8'hF0, 8'h1C}, 1'b0, "t1");
        checkOutput("t1.ascii_a", out_ascii, 8'h61);
        checkOutput("t1.scan_1c", out_scan, 8'h1C);
        checkOutput("t1.count", key_count, 1);
        drain("t1");

        sendBytes('{8'h12}, 1'b0, "t2");
        checkOutput("t2.shift_on", shift_held, 1'b1);
        sendBytes('{8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12}, 1'b0, "t2");
        checkOutput("t2.shift_off", shift_held, 1'b0);
        checkOutput("t2.ascii_A", out_ascii, 8'h41);
        drain("t2");

        sendBytes('{8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h1C}, 1'b0, "t3");
        checkOutput("t3.caps", caps_led, 1'b1);
        checkOutput("t3.first_A", out_ascii, 8'h41);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "t3");
        checkOutput("t3.second_a", out_ascii, 8'h61);
        sendBytes('{8'hF0, 8'h12}, 1'b1, "t3");
        drain("t3");

        for (int i = 0; i <= DEPTH; i++) sendBytes('{8'h16, 8'hF0, 8'h16}, 1'b0, "t4");
        checkOutput("t4.ovf_set", overflow, 1'b1);
        checkOutput("t4.count", key_count, 12);
        checkOutput("t4.head_1", out_ascii, 8'h31);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "t4clr");
        checkOutput("t4.ovf_clr", overflow, 1'b0);
        drain("t4");

        sendBytes('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}, 1'b0, "t5");
        checkOutput("t5.ext_no_push", out_valid, 1'b0);
        sendBytes('{8'h29}, 1'b0, "t5");
        checkOutput("t5.space", out_ascii, 8'h20);
        checkOutput("t5.count", key_count, 13);
        drain("t5");

        sendBytes('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C}, 1'b0, "t6");
`ifdef PS2_TYPEMATIC_FILTER_EN
        checkOutput("t6.count", key_count, 14);
`else
        checkOutput("t6.count", key_count, 16);
`endif
        drain("t6");

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] b;
            int r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: b = letter_codes[$urandom_range(0, 25)];
                3:       b = digit_codes[$urandom_range(0, 9)];
                4:       b = 8'hE0;
                5, 6:    b = 8'hF0;
                7:       b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
                8:       b = 8'h58;
                default: b = 8'($urandom_range(0, 255));
            endcase
            applyStimulus($urandom_range(0, 9) < 7, b, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 19) == 0, "rand");
        end
        scan_valid = 1'b0;
        drain("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
